// File: rtl/fp_align.sv
// fp_align: exponent-alignment stage of the FP adder.
// Right-shifts the significand of the smaller-exponent operand until both
// exponents match. Bits shifted out collapse into the sticky bit (bit 0).
// Optional macro FP_ALIGN_BARREL_EN: shift the whole distance in one ALIGN
// cycle instead of SHIFT_STEP bits per cycle.
module fp_align #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [36:0] NA,
  input  logic [36:0] NB,
  input  logic [1:0]  edata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [36:0] XA,
  output logic [36:0] XB,
  output logic [1:0]  edata_o,
  output logic        shift_b
);

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

  state_t     state;
  logic [4:0] rem;
  logic [7:0] emax;

  logic [7:0]  ea_eff, eb_eff, diff;
  logic [4:0]  rem_in, step;
  logic        a_gt_b;
  logic [27:0] sm_sig, sh_sig;

  // Right shift by s; every bit that falls off (and the old sticky) ORs into bit 0.
  function automatic logic [27:0] shr_sticky(input logic [27:0] sig, input logic [4:0] s);
    logic [28:0] mask;
    logic [27:0] sh;
    logic        lost;
    mask = (29'h1 << s) - 29'h1;
    sh   = sig >> s;
    lost = |(sig & mask[27:0]);
    return {sh[27:1], sh[0] | lost | sig[0]};
  endfunction

  // Operand classification: denormal exponent counts as 1; clamp distance to 28.
  always_comb begin
    ea_eff = (NA[35:28] == 8'd0) ? 8'd1 : NA[35:28];
    eb_eff = (NB[35:28] == 8'd0) ? 8'd1 : NB[35:28];
    a_gt_b = ea_eff > eb_eff;
    diff   = a_gt_b ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
    rem_in = (diff > 8'd28) ? 5'd28 : diff[4:0];
  end

`ifdef FP_ALIGN_BARREL_EN
  // Whole remaining distance in a single pass.
  assign step = rem;
`else
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  // At most STEP bits per ALIGN cycle.
  assign step = (rem < STEP) ? rem : STEP;
`endif

  assign sm_sig   = shift_b ? XB[27:0] : XA[27:0];
  assign sh_sig   = shr_sticky(sm_sig, step);
  assign in_ready = (state == IDLE) && !rst;

  // Control FSM; XA/XB double as the working registers during ALIGN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      XA        <= '0;
      XB        <= '0;
      edata_o   <= '0;
      shift_b   <= 1'b0;
      out_valid <= 1'b0;
      rem       <= '0;
      emax      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            XA      <= NA;
            XB      <= NB;
            edata_o <= edata;
            shift_b <= a_gt_b;
            rem     <= rem_in;
            emax    <= a_gt_b ? ea_eff : eb_eff;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          if (rem == 5'd0) begin
            XA[35:28] <= emax;
            XB[35:28] <= emax;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            if (shift_b) XB[27:0] <= sh_sig;
            else         XA[27:0] <= sh_sig;
            rem <= rem - step;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align.sv
// Scoreboard bench for fp_align: driver pushes hand-computed expectations,
// a monitor pops and compares on the first cycle of each out_valid.
module tb_fp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, shift_b;
  logic [36:0] NA, NB, XA, XB;
  logic [1:0]  edata, edata_o;

  fp_align #(.SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .NA(NA), .NB(NB), .edata(edata), .out_valid(out_valid),
    .out_ready(out_ready), .XA(XA), .XB(XB), .edata_o(edata_o),
    .shift_b(shift_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [36:0] xa;
    logic [36:0] xb;
    logic [1:0]  ed;
    logic        sb;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

`ifdef FP_ALIGN_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  // Single-precision word to the 37-bit extended layout {S,E,H,M,GRS}.
  function automatic logic [36:0] ext(input logic [31:0] f);
    return {f[31], f[30:23], |f[30:23], f[22:0], 4'b0};
  endfunction

  function automatic int lat_of(input int d);
    if (d == 0) return 1;
    if (BARREL) return 2;
    return ((d > 28) ? 28 : d) + 1;
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: compare against the scoreboard head on the first valid cycle.
  bit popped = 1'b0;
  always @(negedge clk) begin
    if (!out_valid) popped = 1'b0;
    else if (!popped) begin
      popped = 1'b1;
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_out: out_valid with empty scoreboard");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("XA", XA, e.xa);
        chk("XB", XB, e.xb);
        chk("edata_o", 37'(edata_o), 37'(e.ed));
        chk("shift_b", 37'(shift_b), 37'(e.sb));
        chk("latency", 37'(cyc - e.acc), 37'(e.lat));
      end
    end
  end

  // Present one operation and hold in_valid over its accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ed);
    @(negedge clk);
    NA = ext(a); NB = ext(b); edata = ed; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout_%s: out_valid never rose, want 1", name);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ed, input logic [36:0] xa, input logic [36:0] xb,
                        input logic sb, input int lat);
    issue(a, b, ed);
    q.push_back('{xa: xa, xb: xb, ed: ed, sb: sb, lat: lat, acc: cyc});
    wait_valid(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    NA = '0; NB = '0; edata = '0;
    #1;
    chk("rst_out_valid", 37'(out_valid), 37'd0);
    chk("rst_in_ready", 37'(in_ready), 37'd0);
    chk("rst_XA", XA, 37'd0);
    chk("rst_XB", XB, 37'd0);
    chk("rst_edata_o", 37'(edata_o), 37'd0);
    chk("rst_shift_b", 37'(shift_b), 37'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // d=1, B shifted: hidden bit moves from bit 27 to bit 26
    run_op("basic", 32'h3F800000, 32'h3F000000, 2'b01,
           ext(32'h3F800000), {1'b0, 8'h7F, 28'h4000000}, 1'b1, lat_of(1));
    // equal exponents: untouched
    run_op("equal", 32'h3F800000, 32'h3FC00000, 2'b01,
           ext(32'h3F800000), ext(32'h3FC00000), 1'b0, lat_of(0));
    // d=40 saturates: only the sticky survives
    run_op("sat", 32'h3F800000, 32'h2B800000, 2'b01,
           ext(32'h3F800000), {1'b0, 8'h7F, 28'h0000001}, 1'b1, lat_of(40));
    // denormal vs smallest normal: both effective exponents are 1
    run_op("denorm", 32'h00800000, 32'h00000001, 2'b10,
           ext(32'h00800000), {1'b0, 8'h01, 28'h0000010}, 1'b0, lat_of(0));
    // A is the smaller operand
    run_op("shift_a", 32'h3F000000, 32'h3F800000, 2'b01,
           {1'b0, 8'h7F, 28'h4000000}, ext(32'h3F800000), 1'b0, lat_of(1));
    // d=5, mantissa LSB falls off into the sticky
    run_op("sticky", 32'h42000000, 32'h3F800001, 2'b01,
           ext(32'h42000000), {1'b0, 8'h84, 28'h0400001}, 1'b1, lat_of(5));
    // zero operand, d=127: sticky stays clear
    run_op("zero", 32'h40000000, 32'h00000000, 2'b10,
           ext(32'h40000000), {1'b0, 8'h80, 28'h0000000}, 1'b1, lat_of(127));

    // backpressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3FC00000, 2'b01);
    q.push_back('{xa: ext(32'h3F800000), xb: ext(32'h3FC00000), ed: 2'b01, sb: 1'b0,
                  lat: lat_of(0), acc: cyc});
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_XA", XA, ext(32'h3F800000));
      chk("bp_XB", XB, ext(32'h3FC00000));
      chk("bp_out_valid", 37'(out_valid), 37'd1);
      chk("bp_in_ready", 37'(in_ready), 37'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 37'(out_valid), 37'd0);
    chk("bp_release_in_ready", 37'(in_ready), 37'd1);

    // reset in the middle of a saturating ALIGN
    issue(32'h3F800000, 32'h2B800000, 2'b01);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 37'(out_valid), 37'd0);
    chk("abort_XA", XA, 37'd0);
    chk("abort_XB", XB, 37'd0);
    chk("abort_in_ready", 37'(in_ready), 37'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", 32'h3F800000, 32'h3F000000, 2'b01,
           ext(32'h3F800000), {1'b0, 8'h7F, 28'h4000000}, 1'b1, lat_of(1));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 37'(q.size()), 37'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
